gfx_vram_writer: RTL and testbench

- Write-side stage directly upstream of the VGA scanout block's VRAM bus.
- Buffers CPU byte writes, plus an internal fill engine for screen clears, in a small FIFO.
- Drains one byte into VRAM in each cycle where the scanout block reports the bus free (its o_free_vbus output).
- Owns the VRAM address/data/write-enable drivers only while writing. Otherwise it tri-states, so scanout fetches are never disturbed.

---
 rtl/gfx_vram_writer.sv | 214 +++++++++++++++++++++
 tb/tb_gfx_vram_writer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_vram_writer.sv
// gfx_vram_writer: write-side stage in front of the scanout block's VRAM bus.
// CPU byte writes and an internal fill engine (screen clears) share a small
// fall-through FIFO. One byte drains into VRAM in every cycle the scanout
// block reports the bus free. The address/data/write-enable drivers are
// owned only in those cycles; otherwise they float so scanout fetches are
// never disturbed.
//
// Handshake: a CPU write transfers on a rising clock edge where
// i_wr_valid && o_wr_ready. The CPU holds i_wr_valid, i_wr_addr and
// i_wr_data stable until that edge. o_wr_ready does not depend on
// i_wr_valid. No request is ever dropped.
module gfx_vram_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    // CPU write port
    input  logic                                 i_wr_valid,
    output logic                                 o_wr_ready,
    input  logic [ADDR_W-1:0]                    i_wr_addr,
    input  logic [7:0]                           i_wr_data,
    // fill engine control
    input  logic                                 i_fill_start,
    input  logic [ADDR_W-1:0]                    i_fill_base,
    input  logic [15:0]                          i_fill_len,
    input  logic [7:0]                           i_fill_value,
    output logic                                 o_fill_busy,
    output logic                                 o_fill_done,
    // VRAM bus, shared with scanout
    input  logic                                 i_free_vbus,
    output logic                                 o_vbus_own,
    output logic [ADDR_W-1:0]                    o_vaddr,
    output logic [7:0]                           o_vdata,
    output logic                                 o_vram_we_b,
    // FIFO occupancy
    output logic [$clog2(FIFO_DEPTH):0]          o_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Fill engine state. fill_state is kept as a named enum signal so
    // checkers and waveforms can observe it directly.
    // ------------------------------------------------------------------
    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_t;

    fill_state_t fill_state;
    fill_state_t fill_state_next;

    logic [ADDR_W-1:0] fill_addr;      // next address the engine will push
    logic [15:0]       fill_remaining; // bytes still to push, 1..len while running
    logic [7:0]        fill_value;     // byte being replicated
    logic              fill_load;      // capture base/len/value this cycle
    logic              fill_push;      // engine enqueues this cycle
    logic              fill_done_next; // done pulse for the next cycle

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [7:0]        mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;

    logic              full;
    logic              empty;
    logic              cpu_push;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic [7:0]        push_data;
    logic [ADDR_W-1:0] head_addr;
    logic [7:0]        head_data;

    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);

    // ------------------------------------------------------------------
    // CPU acceptance. The CPU is shut out while a fill is running so fill
    // bytes stay contiguous; a CPU write accepted in the same cycle as a
    // fill start lands ahead of the first fill byte, because the engine
    // only begins pushing one cycle after the start.
    // ------------------------------------------------------------------
    assign o_fill_busy = (fill_state == FILL_RUN);
    assign o_wr_ready  = !i_rst && !full && !o_fill_busy;
    assign cpu_push    = i_wr_valid && o_wr_ready;

    // The two push sources are mutually exclusive: cpu_push needs the
    // engine idle, fill_push needs it running.
    assign push      = cpu_push || fill_push;
    assign push_addr = cpu_push ? i_wr_addr : fill_addr;
    assign push_data = cpu_push ? i_wr_data : fill_value;

    // ------------------------------------------------------------------
    // Drain. Ownership is purely combinational against the current bus
    // slot so the bus is released in the very cycle i_free_vbus drops,
    // and the instant reset rises.
    // ------------------------------------------------------------------
    assign head_addr   = mem_addr[rd_ptr];
    assign head_data   = mem_data[rd_ptr];
    assign o_vbus_own  = !i_rst && i_free_vbus && !empty;
    assign pop         = o_vbus_own;
    assign o_vram_we_b = !o_vbus_own;
    assign o_vaddr     = o_vbus_own ? head_addr : {ADDR_W{1'bz}};
    assign o_vdata     = o_vbus_own ? head_data : {8{1'bz}};
    assign o_level     = level;

    // Fill engine state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fill_state <= FILL_IDLE;
        end else begin
            fill_state <= fill_state_next;
        end
    end

    // Fill engine next state: start decode and one push per non-full cycle.
    always_comb begin
        fill_state_next = fill_state;
        fill_load       = 1'b0;
        fill_push       = 1'b0;
        fill_done_next  = 1'b0;
        case (fill_state)
            FILL_IDLE: begin
                if (i_fill_start) begin
                    if (i_fill_len == 16'd0) begin
                        // Zero-length fill completes immediately.
                        fill_done_next = 1'b1;
                    end else begin
                        fill_load       = 1'b1;
                        fill_state_next = FILL_RUN;
                    end
                end
            end
            FILL_RUN: begin
                // i_fill_start is ignored here; the running fill finishes.
                if (!full) begin
                    fill_push = 1'b1;
                    if (fill_remaining == 16'd1) begin
                        fill_done_next  = 1'b1;
                        fill_state_next = FILL_IDLE;
                    end
                end
            end
            default: begin
                fill_state_next = FILL_IDLE;
            end
        endcase
    end

    // Fill engine datapath: capture parameters, then step address/count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fill_addr      <= '0;
            fill_remaining <= '0;
            fill_value     <= '0;
        end else if (fill_load) begin
            fill_addr      <= i_fill_base;
            fill_remaining <= i_fill_len;
            fill_value     <= i_fill_value;
        end else if (fill_push) begin
            // Address wraps naturally at the top of VRAM.
            fill_addr      <= fill_addr + 1'b1;
            fill_remaining <= fill_remaining - 16'd1;
        end
    end

    // Done pulse, registered so it appears the cycle after the last push.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_fill_done <= 1'b0;
        end else begin
            o_fill_done <= fill_done_next;
        end
    end

    // FIFO payload storage; contents are don't-care until pointed at.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy; reset discards everything pending.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Depth is a power of two, so pointers wrap by overflow.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_vram_writer.sv
// Directed bench for gfx_vram_writer with a write scoreboard on the VRAM bus.
module tb_gfx_vram_writer;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        fill_start;
    logic [15:0] fill_base;
    logic [15:0] fill_len;
    logic [7:0]  fill_value;
    logic        fill_busy;
    logic        fill_done;
    logic        free;
    logic        own;
    wire  [15:0] vaddr;
    wire  [7:0]  vdata;
    logic        we_b;
    logic [2:0]  level;

    int n_checks = 0;
    int n_errors = 0;
    int wr_count = 0;
    logic [23:0] exp_q[$];

    // Hand-computed tables for the toggling-bus CPU burst.
    logic exp_ready [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int   exp_lvl   [9] = '{0, 1, 1, 2, 2, 3, 3, 4, 3};
    // Hand-computed busy/done per cycle for the wrapping 4-byte fill.
    logic exp_busy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_done  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    gfx_vram_writer #(.FIFO_DEPTH(4), .ADDR_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_valid   (wr_valid),
        .o_wr_ready   (wr_ready),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_fill_start (fill_start),
        .i_fill_base  (fill_base),
        .i_fill_len   (fill_len),
        .i_fill_value (fill_value),
        .o_fill_busy  (fill_busy),
        .o_fill_done  (fill_done),
        .i_free_vbus  (free),
        .o_vbus_own   (own),
        .o_vaddr      (vaddr),
        .o_vdata      (vdata),
        .o_vram_we_b  (we_b),
        .o_level      (level)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: return just after the rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic [15:0] base, input logic [15:0] len, input logic [7:0] val);
        fill_start = 1'b1;
        fill_base  = base;
        fill_len   = len;
        fill_value = val;
        cyc();
        fill_start = 1'b0;
    endtask

    // Bus monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (own === 1'b1) begin
            wr_count++;
            check("own_needs_free", free, 1);
            check("we_b_low", we_b, 0);
            check("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("vram_write", {vaddr, vdata}, exp_q.pop_front());
            end
        end else if (!rst && !free) begin
            check("bus_released", we_b, 1);
        end
    end

    // Stimulus
    initial begin
        int base;
        int w;
        int ndone;
        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_len   = '0;
        fill_value = '0;
        free       = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_level", level, 0);
        check("rst_own", own, 0);
        check("rst_we_b", we_b, 1);
        check("rst_ready", wr_ready, 0);
        check("rst_busy", fill_busy, 0);
        check("rst_done", fill_done, 0);
        cyc();
        rst  = 1'b0;
        free = 1'b1;
        @(negedge clk);
        check("ready_after_rst", wr_ready, 1);
        cyc();

        // Single CPU write, bus always free
        base     = wr_count;
        wr_valid = 1'b1;
        wr_addr  = 16'h1234;
        wr_data  = 8'hAB;
        exp_q.push_back(24'h1234AB);
        cyc();
        wr_valid = 1'b0;
        @(negedge clk);
        check("t1_own", own, 1);
        check("t1_vaddr", vaddr, 16'h1234);
        check("t1_vdata", vdata, 8'hAB);
        check("t1_we_b", we_b, 0);
        check("t1_level", level, 1);
        cyc();
        @(negedge clk);
        check("t1_own_after", own, 0);
        check("t1_level_after", level, 0);
        cyc();
        check("t1_writes", wr_count - base, 1);

        // CPU burst against a bus free every other cycle; FIFO reaches full
        base = wr_count;
        w    = 0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({16'(16'h2000 + i), 8'(8'h10 + i)});
        end
        for (int c = 0; c < 9; c++) begin
            free     = (c % 2) == 1;
            wr_valid = 1'b1;
            wr_addr  = 16'(16'h2000 + w);
            wr_data  = 8'(8'h10 + w);
            @(negedge clk);
            check($sformatf("t2_ready_c%0d", c), wr_ready, exp_ready[c]);
            check($sformatf("t2_level_c%0d", c), level, exp_lvl[c]);
            cyc();
            if (exp_ready[c]) w++;
        end
        wr_valid = 1'b0;
        for (int c = 9; c < 18; c++) begin
            free = (c % 2) == 1;
            cyc();
        end
        free = 1'b0;
        @(negedge clk);
        check("t2_level_drained", level, 0);
        cyc();
        check("t2_writes", wr_count - base, 8);

        // Fill wrapping through the top of VRAM, bus always free
        free = 1'b1;
        base = wr_count;
        exp_q.push_back(24'hFFFE55);
        exp_q.push_back(24'hFFFF55);
        exp_q.push_back(24'h000055);
        exp_q.push_back(24'h000155);
        start_fill(16'hFFFE, 16'd4, 8'h55);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("t3_busy_%0d", k), fill_busy, exp_busy[k]);
            check($sformatf("t3_done_%0d", k), fill_done, exp_done[k]);
            if (k == 0) check("t3_cpu_blocked", wr_ready, 0);
            cyc();
        end
        @(negedge clk);
        check("t3_level", level, 0);
        cyc();
        check("t3_writes", wr_count - base, 4);

        // Zero-length fill
        base = wr_count;
        start_fill(16'h0100, 16'd0, 8'h77);
        @(negedge clk);
        check("t4_done", fill_done, 1);
        check("t4_busy", fill_busy, 0);
        cyc();
        @(negedge clk);
        check("t4_done_once", fill_done, 0);
        check("t4_busy_after", fill_busy, 0);
        check("t4_level", level, 0);
        cyc();
        check("t4_writes", wr_count - base, 0);

        // Long fill stalls on a busy bus, then drains
        free = 1'b0;
        base = wr_count;
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back({16'(16'h3000 + i), 8'hA5});
        end
        start_fill(16'h3000, 16'd100, 8'hA5);
        repeat (6) cyc();
        @(negedge clk);
        check("t5_level_full", level, 4);
        check("t5_busy_stall", fill_busy, 1);
        check("t5_done_stall", fill_done, 0);
        check("t5_ready_stall", wr_ready, 0);
        cyc();
        free  = 1'b1;
        ndone = 0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (fill_done) begin
                ndone++;
                check("t5_done_after_last", (wr_count - base) + int'(level), 100);
                check("t5_busy_at_done", fill_busy, 0);
            end
            if (ndone > 0 && level == 3'd0) break;
        end
        check("t5_done_count", ndone, 1);
        check("t5_writes", wr_count - base, 100);

        // Reset in the middle of a fill with three entries pending
        free = 1'b0;
        start_fill(16'h4000, 16'd100, 8'h11);
        repeat (3) cyc();
        @(negedge clk);
        check("t6_level_pre", level, 3);
        check("t6_busy_pre", fill_busy, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_own", own, 0);
        check("t6_rst_we_b", we_b, 1);
        check("t6_rst_level", level, 0);
        check("t6_rst_busy", fill_busy, 0);
        check("t6_rst_ready", wr_ready, 0);
        cyc();
        rst  = 1'b0;
        free = 1'b1;
        base = wr_count;
        repeat (10) cyc();
        check("t6_level_post", level, 0);
        check("t6_busy_post", fill_busy, 0);
        check("t6_done_post", fill_done, 0);
        check("t6_no_stale", wr_count - base, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
